// File: rtl/cache_sram_bridge.sv
// -----------------------------------------------------------------------------
// cache_sram_bridge
//
// Bridges a cache's read/write request interface onto an SRAM-style bus with a
// split address phase (req/addr_ok) and data phase (data_ok/rdata). Line
// transfers are expanded into LINE_WORDS consecutive word beats starting at the
// line-aligned base. Address beats may run ahead of the data phase, so several
// beats can be outstanding at once.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr       cache read request (type 000/001/010/100)
//   rd_rdy                       read accepted this cycle (IDLE, no write pending)
//   ret_valid/ret_last/ret_data  read return beats, passed straight from the bus
//   wr_req/wr_type/wr_addr       cache write request
//   wr_wstrb/wr_data             byte strobe (single writes), line data
//   wr_rdy                       write accepted this cycle (IDLE)
//   req/wr/size/addr/wstrb/wdata SRAM bus address phase
//   addr_ok/data_ok/rdata        SRAM bus handshakes and read data
// -----------------------------------------------------------------------------
module cache_sram_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  // cache read side
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  // cache write side
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  // SRAM bus
  output logic                    req,
  output logic                    wr,
  output logic [1:0]              size,
  output logic [31:0]             addr,
  output logic [3:0]              wstrb,
  output logic [31:0]             wdata,
  input  logic                    addr_ok,
  input  logic                    data_ok,
  input  logic [31:0]             rdata
);

  // Counters must hold the value LINE_WORDS itself (all beats issued).
  localparam int CNT_W = $clog2(LINE_WORDS + 1);
  // Byte-offset bits cleared to form the line base address.
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t                  state, state_next;
  logic [2:0]              lat_type;
  logic [31:0]             lat_addr;
  logic [3:0]              lat_wstrb;
  logic [32*LINE_WORDS-1:0] lat_data;
  logic [CNT_W-1:0]        issued;   // address beats accepted by addr_ok
  logic [CNT_W-1:0]        done;     // data beats completed by data_ok

  logic                    is_line;
  logic [CNT_W-1:0]        beats;
  logic                    last_beat;
  logic [31:0]             line_base;

  // ---------------------------------------------------------------------------
  // State register and request/counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      issued    <= '0;
      done      <= '0;
      lat_type  <= '0;
      lat_addr  <= '0;
      lat_wstrb <= '0;
      // NOTE: the wide line-data register is a plain flop bank, not a RAM, so
      // it is cheap to clear here and keeps a cleared request fully defined.
      lat_data  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        issued <= '0;
        done   <= '0;
        // Write-back takes priority over refill when both are pending.
        if (wr_req) begin
          lat_type  <= wr_type;
          lat_addr  <= wr_addr;
          lat_wstrb <= wr_wstrb;
          lat_data  <= wr_data;
        end else if (rd_req) begin
          lat_type <= rd_type;
          lat_addr <= rd_addr;
        end
      end else begin
        // Both handshakes may land in the same cycle; each counter is
        // advanced independently.
        if (req && addr_ok) begin
          issued <= issued + CNT_W'(1);
        end
        if (data_ok && (done < beats)) begin
          done <= done + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat bookkeeping
  // ---------------------------------------------------------------------------
  assign is_line   = (lat_type == TYPE_LINE);
  assign beats     = is_line ? CNT_W'(LINE_WORDS) : CNT_W'(1);
  assign last_beat = (done == (beats - CNT_W'(1)));
  assign line_base = {lat_addr[31:OFF_W], {OFF_W{1'b0}}};

  // Read data is forwarded with no added latency; ret_valid qualifies it.
  assign ret_data = rdata;

  // ---------------------------------------------------------------------------
  // Next-state and bus outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    rd_rdy     = 1'b0;
    wr_rdy     = 1'b0;
    req        = 1'b0;
    wr         = 1'b0;
    ret_valid  = 1'b0;
    ret_last   = 1'b0;
    size       = is_line ? 2'd2 : lat_type[1:0];
    addr       = is_line ? (line_base + (32'(issued) << 2)) : lat_addr;
    wstrb      = is_line ? 4'hf : lat_wstrb;
    wdata      = lat_data[31:0];

    // Select the next unissued word of the line. Once all beats are issued
    // req is low, so the value is irrelevant and word 0 is left in place.
    if (is_line) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (issued == CNT_W'(k)) begin
          wdata = lat_data[32*k +: 32];
        end
      end
    end

    case (state)
      IDLE: begin
        wr_rdy = 1'b1;
        rd_rdy = !wr_req;
        if (wr_req) begin
          state_next = WR;
        end else if (rd_req) begin
          state_next = RD;
        end
      end
      RD: begin
        req       = (issued < beats);
        ret_valid = data_ok;
        ret_last  = data_ok && last_beat;
        if (data_ok && last_beat) begin
          state_next = IDLE;
        end
      end
      WR: begin
        req = (issued < beats);
        wr  = 1'b1;
        if (data_ok && last_beat) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_cache_sram_bridge
//
// Directed vectors with hand-computed bus beats and return beats. Each
// stimulus task pushes the beats it expects into scoreboard queues; a monitor
// pops and compares whenever the DUT fires an address beat (req & addr_ok) or a
// return beat (ret_valid). A small SRAM slave answers each accepted address
// beat with data_ok one cycle later, returning addr ^ RD_KEY as read data.
// -----------------------------------------------------------------------------
module tb_cache_sram_bridge;

  localparam int LW = 4;
  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

  logic              clk;
  logic              resetn;
  logic              rd_req;
  logic [2:0]        rd_type;
  logic [31:0]       rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;
  logic              wr_req;
  logic [2:0]        wr_type;
  logic [31:0]       wr_addr;
  logic [3:0]        wr_wstrb;
  logic [32*LW-1:0]  wr_data;
  logic              wr_rdy;
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  cache_sram_bridge #(.LINE_WORDS(LW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } ret_t;

  beat_t exp_beats[$];
  ret_t  exp_rets[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected event, value 0x%08h at %0t", name, act, $time);
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [3:0] st, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.wr = w; b.size = s; b.wstrb = st; b.wdata = d;
    exp_beats.push_back(b);
  endtask

  task automatic exp_ret(input logic [31:0] d, input logic l);
    ret_t r;
    r.data = d; r.last = l;
    exp_rets.push_back(r);
  endtask

  // Read beat plus its return beat.
  task automatic exp_rd(input logic [31:0] a, input logic [1:0] s, input logic l);
    exp_beat(a, 1'b0, s, 4'h0, 32'h0);
    exp_ret(a ^ RD_KEY, l);
  endtask

  // Monitor: compares every fired beat / return beat against the queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (req && addr_ok) begin
        if (exp_beats.size() == 0) begin
          flag("beat_unexpected", addr);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_addr", addr, b.addr);
          check("beat_wr", 32'(wr), 32'(b.wr));
          check("beat_size", 32'(size), 32'(b.size));
          if (b.wr) begin
            check("beat_wstrb", 32'(wstrb), 32'(b.wstrb));
            check("beat_wdata", wdata, b.wdata);
          end
        end
      end else if (req && exp_beats.size() > 0) begin
        // Stalled beat: address must stay on the next unissued beat.
        check("stall_addr", addr, exp_beats[0].addr);
      end
      if (ret_valid) begin
        if (exp_rets.size() == 0) begin
          flag("ret_unexpected", ret_data);
        end else begin
          ret_t r;
          r = exp_rets.pop_front();
          check("ret_data", ret_data, r.data);
          check("ret_last", 32'(ret_last), 32'(r.last));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM slave: data_ok one cycle after each accepted address beat
  // ---------------------------------------------------------------------------
  logic        pend;
  logic [31:0] pend_data;
  logic        stray_dok;

  initial begin
    pend = 1'b0;
    pend_data = 32'h0;
    stray_dok = 1'b0;
  end

  always @(negedge clk) begin
    pend = req && addr_ok && resetn;
    pend_data = addr ^ RD_KEY;
  end

  always @(posedge clk) begin
    #1;
    data_ok = pend | stray_dok;
    rdata   = pend ? pend_data : 32'hDEAD_BEEF;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_read(input logic [2:0] t, input logic [31:0] a);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    @(negedge clk);
    check("rd_rdy_accept", 32'(rd_rdy), 32'd1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] st, input logic [32*LW-1:0] d);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = st; wr_data = d;
    @(negedge clk);
    check("wr_rdy_accept", 32'(wr_rdy), 32'd1);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  // Counts busy cycles (wr_rdy low) until the bridge is idle again.
  task automatic wait_idle(input string name, input int exp_busy);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_busy));
    check({name, "_rd_rdy"}, 32'(rd_rdy), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = '0;
    addr_ok = 1'b1; data_ok = 1'b0; rdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req", 32'(req), 32'd0);
    check("reset_ret_valid", 32'(ret_valid), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_rd_rdy", 32'(rd_rdy), 32'd1);
    check("post_reset_wr_rdy", 32'(wr_rdy), 32'd1);
    check("post_reset_wr", 32'(wr), 32'd0);
    @(posedge clk); #1;

    // Line read at 0x1C00_0014: beats from the aligned base 0x1C00_0010.
    exp_rd(32'h1C00_0010, 2'd2, 1'b0);
    exp_rd(32'h1C00_0014, 2'd2, 1'b0);
    exp_rd(32'h1C00_0018, 2'd2, 1'b0);
    exp_rd(32'h1C00_001C, 2'd2, 1'b1);
    do_read(3'b100, 32'h1C00_0014);
    wait_idle("line_read_busy", 5);

    // Line write at 0x0000_2040, words A0..A3, full strobes.
    exp_beat(32'h0000_2040, 1'b1, 2'd2, 4'hf, 32'h0000_00A0);
    exp_beat(32'h0000_2044, 1'b1, 2'd2, 4'hf, 32'h0000_00A1);
    exp_beat(32'h0000_2048, 1'b1, 2'd2, 4'hf, 32'h0000_00A2);
    exp_beat(32'h0000_204C, 1'b1, 2'd2, 4'hf, 32'h0000_00A3);
    do_write(3'b100, 32'h0000_2040, 4'h1,
             {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0});
    wait_idle("line_write_busy", 5);

    // Single byte read at 0x0000_0003: address passed unchanged, size 0.
    exp_rd(32'h0000_0003, 2'd0, 1'b1);
    do_read(3'b000, 32'h0000_0003);
    wait_idle("byte_read_busy", 2);

    // Single half read at 0x0000_0102.
    exp_rd(32'h0000_0102, 2'd1, 1'b1);
    do_read(3'b001, 32'h0000_0102);
    wait_idle("half_read_busy", 2);

    // Write and read requested together: write first, then the read.
    exp_beat(32'h0000_0200, 1'b1, 2'd2, 4'h5, 32'h1234_5678);
    exp_rd(32'h0000_0300, 2'd2, 1'b1);
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_0200; wr_wstrb = 4'h5;
    wr_data = {96'h0, 32'h1234_5678};
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0300;
    @(negedge clk);
    check("both_wr_rdy", 32'(wr_rdy), 32'd1);
    check("both_rd_rdy", 32'(rd_rdy), 32'd0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rd_rdy && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("both_write_busy", 32'(n), 32'd2);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_idle("both_read_busy", 2);

    // Line read with addr_ok held low for 5 cycles after the first beat.
    exp_rd(32'h0000_8000, 2'd2, 1'b0);
    exp_rd(32'h0000_8004, 2'd2, 1'b0);
    exp_rd(32'h0000_8008, 2'd2, 1'b0);
    exp_rd(32'h0000_800C, 2'd2, 1'b1);
    do_read(3'b100, 32'h0000_800C);
    @(negedge clk);
    @(posedge clk); #1;
    addr_ok = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 32'(req), 32'd1);
    end
    @(posedge clk); #1;
    addr_ok = 1'b1;
    begin
      int n;
      n = 6;
      @(negedge clk);
      while (!wr_rdy && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("stall_read_busy", 32'(n), 32'd10);
    end
    @(posedge clk); #1;

    // Reset after two of four returns, then a stray data_ok.
    exp_rd(32'h0000_4000, 2'd2, 1'b0);
    exp_rd(32'h0000_4004, 2'd2, 1'b0);
    exp_beat(32'h0000_4008, 1'b0, 2'd2, 4'h0, 32'h0);
    exp_beat(32'h0000_400C, 1'b0, 2'd2, 4'h0, 32'h0);
    do_read(3'b100, 32'h0000_4008);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("abort_rets_seen", 32'(exp_rets.size()), 32'd0);
    exp_beats.delete();
    exp_rets.delete();
    @(negedge clk);
    check("abort_req", 32'(req), 32'd0);
    check("abort_ret_valid", 32'(ret_valid), 32'd0);
    check("abort_ret_last", 32'(ret_last), 32'd0);
    check("abort_wr", 32'(wr), 32'd0);
    check("abort_rd_rdy", 32'(rd_rdy), 32'd1);
    check("abort_wr_rdy", 32'(wr_rdy), 32'd1);
    stray_dok = 1'b1;
    @(negedge clk);
    check("stray_data_ok_seen", 32'(data_ok), 32'd1);
    check("stray_ret_valid", 32'(ret_valid), 32'd0);
    check("stray_req", 32'(req), 32'd0);
    stray_dok = 1'b0;
    @(posedge clk); #1;

    // Normal read after the abort.
    exp_rd(32'h0000_0044, 2'd2, 1'b1);
    do_read(3'b010, 32'h0000_0044);
    wait_idle("after_abort_busy", 2);

    repeat (2) @(posedge clk);
    check("beats_left", 32'(exp_beats.size()), 32'd0);
    check("rets_left", 32'(exp_rets.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_sram_bridge.md
CACHE_SRAM_BRIDGE -- requirements
Module: cache_sram_bridge

Interface
REQ-001 Parameter LINE_WORDS, default 4: words per cache line; line transfers use 32*LINE_WORDS-bit write data.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, synchronous and active-low.
REQ-004 rd_req  in  1  cache read request.
REQ-005 rd_type  in  3  read type: 000 byte, 001 half, 010 word, 100 line.
REQ-006 rd_addr  in  32  read address.
REQ-007 rd_rdy  out  1  read request accepted this cycle.
REQ-008 ret_valid  out  1  ret_data valid.
REQ-009 ret_last  out  1  final return beat.
REQ-010 ret_data  out  32  returned word.
REQ-011 wr_req, wr_type, wr_addr, wr_wstrb  in  1/3/32/4  write request, type encoded as rd_type, address, byte strobe.
REQ-012 wr_data  in  32*LINE_WORDS  write data; word k in bits [32k+31:32k]; single writes use word 0.
REQ-013 wr_rdy  out  1  write request accepted this cycle.
REQ-014 req, wr  out  1/1  SRAM-bus request and write flag.
REQ-015 size  out  2  SRAM-bus size: 0 byte, 1 half, 2 word.
REQ-016 addr, wstrb, wdata  out  32/4/32  SRAM-bus address, strobe, write data.
REQ-017 addr_ok, data_ok, rdata  in  1/1/32  SRAM-bus address accepted, data phase done, read data.

Function
REQ-018 States: IDLE, RD, WR; reset state IDLE.
REQ-019 wr_rdy shall be 1 only in IDLE; rd_rdy shall be 1 only in IDLE with wr_req=0, so a write-back is served before a refill.
REQ-020 Acceptance: rd_req&rd_rdy latches type/address, IDLE->RD; wr_req&wr_rdy latches type/address/strobe/data, IDLE->WR.
REQ-021 Beat count: LINE_WORDS for type 100, otherwise 1.
REQ-022 Line address: base = address with low log2(LINE_WORDS)+2 bits cleared; beat k address = base+4k. Single-beat address is passed unchanged.
REQ-023 In RD/WR, req=1 while issued count < beat count; issued count increments on req&addr_ok; addr/wdata/wstrb shall reflect the next unissued beat.
REQ-024 req may issue back-to-back beats before earlier data_ok; outstanding beats bounded only by beat count.
REQ-025 size = 2 for line beats, rd_type[1:0]/wr_type[1:0] for single beats; wr=1 only in WR.
REQ-026 wstrb = 4'hf for line writes, latched wr_wstrb for single writes; don't-care in RD.
REQ-027 RD: each data_ok drives ret_valid=1 and ret_data=rdata in the same cycle (combinational, zero added latency); ret_last=1 on the data_ok completing the final beat.
REQ-028 RD->IDLE and WR->IDLE on the data_ok of the final beat; the new request may be accepted in the following cycle.
REQ-029 WR produces no ret_valid; completion is visible only as wr_rdy reasserting.
REQ-030 data_ok in IDLE shall be ignored; ret_valid=0 outside RD.
REQ-031 addr_ok and data_ok in the same cycle shall both be counted.
REQ-032 Counters shall be wide enough for LINE_WORDS with no wrap within a transfer.

Reset
REQ-033 With resetn=0 at a clock edge: state IDLE, counters 0, latched request cleared; req=0, wr=0, ret_valid=0, ret_last=0; rd_rdy and wr_rdy follow REQ-019 from the next cycle.
REQ-034 Reset mid-transfer aborts it; no ret_valid for the aborted transfer, and late data_ok after reset shall be ignored.

Verification
REQ-035 Line read rd_addr=0x1C00_0014, type 100, addr_ok always 1, data_ok one cycle after each beat -> addresses 0x1C00_0010/14/18/1C; four ret_valid beats, ret_last only on the 4th; rd_rdy=1 the cycle after.
REQ-036 Line write wr_addr=0x0000_2040, wr_data words 0xA0..0xA3 -> four req with wr=1, wstrb=f, size=2, wdata in order A0..A3; wr_rdy=0 until the 4th data_ok; ret_valid stays 0.
REQ-037 rd_req and wr_req asserted together in IDLE -> wr_rdy=1, rd_rdy=0; write completes first, then the read is accepted.
REQ-038 Single byte read type 000 at 0x0000_0003 -> one beat, size=0, addr=0x0000_0003, ret_valid and ret_last together.
REQ-039 addr_ok held 0 for 5 cycles during a line read -> req and beat address hold steady; no beat skipped or duplicated.
REQ-040 resetn=0 after 2 of 4 read beats return, then a stray data_ok -> outputs at reset values, no ret_valid, next rd_req accepted normally.
